// File: rtl/seq_normalizer32_pkg.sv
// seq_normalizer32_pkg: shared constants for the multicycle normalizer.
// Holds the FSM state encodings, datapath widths, the index of the final
// binary-search stage and the helper that maps a stage index to its step.
// Optional feature macro used elsewhere in this slice: ROUNDTRIP_CHECK_EN.
package seq_normalizer32_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int SHIFT_WIDTH = 5;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic [2:0] LAST_STAGE = 3'd4;

   // Stage k examines a window of 16>>k bits; that same value is also the
   // weight of the shift-count bit the stage is responsible for.
   function automatic logic [SHIFT_WIDTH-1:0] stageStep(input logic [2:0] stage);
      return SHIFT_WIDTH'(DATA_WIDTH / 2) >> stage;
   endfunction

endpackage

// File: rtl/seq_normalizer32_barrel.sv
// BARREL_SHIFTER32: combinational 32-bit logical shifter from the datapath.
// LnR = 1 shifts left, LnR = 0 shifts right; any shift of 32 or more gives 0.
// Only compiled when ROUNDTRIP_CHECK_EN is defined, since nothing else uses it.
`ifdef ROUNDTRIP_CHECK_EN
module BARREL_SHIFTER32 (
   output logic [31:0] Y,
   input  logic [31:0] D,
   input  logic [31:0] S,
   input  logic        LnR
);

   // Out-of-range amounts flush the word; otherwise a plain logical shift
   always_comb begin
      Y = '0;
      if (S[31:5] == '0) begin
         Y = LnR ? (D << S[4:0]) : (D >> S[4:0]);
      end
   end

endmodule
`endif

// File: rtl/seq_normalizer32_norm_step.sv
// norm_step: one combinational binary-search stage of the normalizer.
// If the step-wide window at the chosen edge is all zeros the word is shifted
// by step towards that edge (vacated bits are zero) and o_hit is raised.
// i_dir = 1 looks at the MSB end (left), i_dir = 0 at the LSB end (right).
module norm_step
   import seq_normalizer32_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]  i_word,
   input  logic [SHIFT_WIDTH-1:0] i_step,
   input  logic                   i_dir,
   output logic [DATA_WIDTH-1:0]  o_word,
   output logic                   o_hit
);

   logic [DATA_WIDTH-1:0] w_edgeMask;

   // Build the edge window mask, test it, and shift past it when it is empty
   always_comb begin
      w_edgeMask = '0;
      o_hit      = 1'b0;
      o_word     = i_word;
      if (i_dir) begin
         w_edgeMask = ~({DATA_WIDTH{1'b1}} >> i_step);
         o_hit      = ((i_word & w_edgeMask) == '0);
         if (o_hit) o_word = i_word << i_step;
      end else begin
         w_edgeMask = ~({DATA_WIDTH{1'b1}} << i_step);
         o_hit      = ((i_word & w_edgeMask) == '0);
         if (o_hit) o_word = i_word >> i_step;
      end
   end

endmodule

// File: rtl/seq_normalizer32.sv
// seq_normalizer32: multicycle 32-bit left/right normalizer (count leading or
// trailing zeros) with a START/DONE handshake. Five binary-search stages run
// one per clock through a single norm_step instance indexed by the stage count.
// Optional macro ROUNDTRIP_CHECK_EN adds CHK_ERR, which re-shifts the result
// through BARREL_SHIFTER32 and compares it against the captured operand.
module seq_normalizer32
   import seq_normalizer32_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic [DATA_WIDTH-1:0]  D,
   input  logic                   LnR,
   output logic [DATA_WIDTH-1:0]  Y,
   output logic [SHIFT_WIDTH-1:0] S,
   output logic                   ZERO,
   output logic                   BUSY,
   output logic                   DONE
`ifdef ROUNDTRIP_CHECK_EN
   ,
   output logic                   CHK_ERR
`endif
);

   logic [1:0]             r_state;
   logic [2:0]             r_stage;
   logic [DATA_WIDTH-1:0]  r_y;
   logic [SHIFT_WIDTH-1:0] r_s;
   logic                   r_zero;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_lnr;

   logic [SHIFT_WIDTH-1:0] w_step;
   logic [DATA_WIDTH-1:0]  w_yNext;
   logic                   w_hit;
   logic [SHIFT_WIDTH-1:0] w_sNext;
   logic                   w_accept;
   logic                   w_lastStage;

   assign w_step      = stageStep(r_stage);
   assign w_sNext     = r_s | (w_hit ? w_step : '0);
   assign w_accept    = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_lastStage = (r_state == ST_RUN) && (r_stage == LAST_STAGE);

   norm_step u_normStep (
      .i_word (r_y),
      .i_step (w_step),
      .i_dir  (r_lnr),
      .o_word (w_yNext),
      .o_hit  (w_hit)
   );

   // Control FSM and datapath registers: accept, five search stages, DONE pulse
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_y     <= '0;
         r_s     <= '0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lnr   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (START) begin
                  r_state <= ST_RUN;
                  r_y     <= D;
                  r_lnr   <= LnR;
                  r_s     <= '0;
                  r_zero  <= 1'b0;
                  r_stage <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_y <= w_yNext;
               r_s <= w_sNext;
               if (r_stage == LAST_STAGE) begin
                  r_zero  <= (w_yNext == '0);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_stage <= r_stage + 3'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ROUNDTRIP_CHECK_EN
   logic [DATA_WIDTH-1:0] r_d;
   logic                  r_chkErr;
   logic [DATA_WIDTH-1:0] w_rtWord;

   BARREL_SHIFTER32 u_roundTrip (
      .Y   (w_rtWord),
      .D   (w_yNext),
      .S   ({{(32-SHIFT_WIDTH){1'b0}}, w_sNext}),
      .LnR (~r_lnr)
   );

   // Keep a copy of the operand and judge the inverse shift as DONE is raised
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_d      <= '0;
         r_chkErr <= 1'b0;
      end else begin
         if (w_accept) r_d <= D;
         if (w_lastStage) r_chkErr <= (w_rtWord != r_d) && (w_yNext != '0);
      end
   end

   assign CHK_ERR = r_chkErr;
`else
   logic w_unusedAccept;
   logic w_unusedLast;
   assign w_unusedAccept = w_accept;
   assign w_unusedLast   = w_lastStage;
`endif

   assign Y    = r_y;
   assign S    = r_s;
   assign ZERO = r_zero;
   assign BUSY = r_busy;
   assign DONE = r_done;

endmodule

// File: tb/tb_seq_normalizer32.sv
// tb_seq_normalizer32: scoreboard bench for seq_normalizer32.
// Each accepted operation pushes its expected result (from a plain zero-count
// model) into a queue; a monitor pops and compares whenever DONE is seen.
// Honours ROUNDTRIP_CHECK_EN by also expecting CHK_ERR to stay low.
module tb_seq_normalizer32;

   logic        CLK   = 1'b0;
   logic        RST   = 1'b1;
   logic        START = 1'b0;
   logic [31:0] D     = '0;
   logic        LnR   = 1'b0;
   logic [31:0] Y;
   logic [4:0]  S;
   logic        ZERO;
   logic        BUSY;
   logic        DONE;
`ifdef ROUNDTRIP_CHECK_EN
   logic        CHK_ERR;
`endif

   typedef struct packed {
      logic [31:0] y;
      logic [4:0]  s;
      logic        zero;
   } expT;

   expT scoreQ[$];
   int  compared   = 0;
   int  mismatched = 0;

   seq_normalizer32 dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .D     (D),
      .LnR   (LnR),
      .Y     (Y),
      .S     (S),
      .ZERO  (ZERO),
      .BUSY  (BUSY),
      .DONE  (DONE)
`ifdef ROUNDTRIP_CHECK_EN
      ,
      .CHK_ERR (CHK_ERR)
`endif
   );

   // Free-running 100 MHz clock
   always #5 CLK = ~CLK;

   // Reference: count zeros from the chosen edge, then shift them out
   function automatic expT refModel(input logic [31:0] d, input logic lnr);
      expT e;
      int  n;
      if (d == 32'h0) begin
         e.y    = 32'h0;
         e.s    = 5'd31;
         e.zero = 1'b1;
         return e;
      end
      n = 0;
      if (lnr) begin
         while (d[31-n] == 1'b0) n++;
         e.y = d << n;
      end else begin
         while (d[n] == 1'b0) n++;
         e.y = d >> n;
      end
      e.s    = 5'(n);
      e.zero = 1'b0;
      return e;
   endfunction

   // One comparison: count it, and report it when it does not match
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every DONE pulse must match the oldest outstanding expectation
   always @(negedge CLK) begin : monitor
      expT e;
      if (RST && DONE) begin
         if (scoreQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got DONE=1 with no request outstanding, expected DONE=0");
         end else begin
            e = scoreQ.pop_front();
            checkOutput("Y", Y, e.y);
            checkOutput("S", 32'(S), 32'(e.s));
            checkOutput("ZERO", 32'(ZERO), 32'(e.zero));
`ifdef ROUNDTRIP_CHECK_EN
            checkOutput("CHK_ERR", 32'(CHK_ERR), 32'h0);
`endif
         end
      end
   end

   // Issue one op from a negedge where the DUT can accept; return on DONE.
   // With disturb set, START is pulsed and D scrambled in the middle of RUN.
   task automatic applyStimulus(input logic [31:0] d, input logic lnr, input bit disturb);
      int cycles;
      int busyCycles;
      bit seen;
      START = 1'b1;
      D     = d;
      LnR   = lnr;
      @(posedge CLK);
      scoreQ.push_back(refModel(d, lnr));
      #1;
      START = 1'b0;
      D     = $urandom;
      LnR   = 1'($urandom_range(0, 1));
      cycles     = 0;
      busyCycles = 0;
      seen       = 1'b0;
      while (!seen && cycles < 20) begin
         @(negedge CLK);
         cycles++;
         if (DONE) seen = 1'b1;
         else if (BUSY) busyCycles++;
         if (disturb && cycles == 2) begin
            START = 1'b1;
            D     = $urandom;
            LnR   = ~lnr;
         end
         if (disturb && cycles == 3) START = 1'b0;
      end
      checkOutput("latency", 32'(cycles), 32'd6);
      checkOutput("busy_cycles", 32'(busyCycles), 32'd5);
   endtask

   // One quiet cycle after an op: DONE must have dropped, BUSY stays low
   task automatic idleCycle();
      @(negedge CLK);
      checkOutput("done_single_pulse", 32'(DONE), 32'h0);
      checkOutput("busy_idle", 32'(BUSY), 32'h0);
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at 200us, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, random ops, mid-run reset
   initial begin : stimulus
      logic [31:0] rd;
      bit          sawDone;
      #3 RST = 1'b0;
      #4;
      checkOutput("reset_Y", Y, 32'h0);
      checkOutput("reset_S", 32'(S), 32'h0);
      checkOutput("reset_flags", {28'h0, ZERO, BUSY, DONE, 1'b0}, 32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      idleCycle();

      applyStimulus(32'h00000001, 1'b1, 1'b0);
      idleCycle();
      applyStimulus(32'h80000000, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h0000F000, 1'b1, 1'b0);
      idleCycle();
      applyStimulus(32'h101F568A, 1'b1, 1'b0);
      applyStimulus(32'h198AF7B1, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h00000000, 1'b1, 1'b0);
      applyStimulus(32'h00000000, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h00A50000, 1'b0, 1'b1);
      idleCycle();
      applyStimulus(32'h00000300, 1'b1, 1'b1);
      applyStimulus(32'hFFFFFFFF, 1'b1, 1'b0);
      idleCycle();

      for (int i = 0; i < 60; i++) begin
         rd = $urandom;
         if ($urandom_range(0, 1) == 1) rd = rd >> $urandom_range(0, 31);
         else rd = rd << $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) rd = 32'h0;
         applyStimulus(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();

      START = 1'b1;
      D     = 32'h00001234;
      LnR   = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      checkOutput("midrun_reset_Y", Y, 32'h0);
      checkOutput("midrun_reset_S", 32'(S), 32'h0);
      checkOutput("midrun_reset_flags", {28'h0, ZERO, BUSY, DONE, 1'b0}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      sawDone = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (DONE || BUSY) sawDone = 1'b1;
      end
      checkOutput("no_done_after_reset", 32'(sawDone), 32'h0);

      applyStimulus(32'h00400000, 1'b0, 1'b0);
      idleCycle();
      checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_normalizer32.md
Name: seq_normalizer32

Overview:
Multicycle 32-bit normalizer for the CS147 datapath.
- Given an operand D and a direction, it finds the shift amount that brings the first set bit to the chosen edge. LnR=1 is a left normalize (leading zeros, MSB aligned); LnR=0 is a right normalize (trailing zeros, LSB aligned).
- Outputs are the normalized word Y and the shift count S.
- It inverts BARREL_SHIFTER32: shifting Y by S in the opposite direction reproduces D.
- It uses a START/DONE handshake and sits beside the ALU for count-leading-zeros and normalize operations.

Parameters:
- DATA_WIDTH, 32, operand width.
- SHIFT_WIDTH, 5, shift-count width. Must satisfy 2^SHIFT_WIDTH == DATA_WIDTH; only 32/5 is required.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request. Sampled only in IDLE or DONE state.
- D  input  32  operand, captured on the accepted START edge.
- LnR  input  1  direction, captured with D: 1 = left normalize, 0 = right normalize.
- Y  output  32  normalized result.
- S  output  5  shift count applied.
- ZERO  output  1  captured operand was 0.
- BUSY  output  1  high from the accept edge until the result is complete.
- DONE  output  1  one-cycle pulse marking result valid.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; Y=0, S=0, ZERO=0, BUSY=0, DONE=0; stage counter=0. This applies mid-operation too; the in-flight result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on START=1: Y<=D, latch LnR, S<=0, ZERO<=0, stage<=0, BUSY<=1.
  - RUN: one binary-search stage per edge, stage k = 0..4, step = 16>>k.
    - Left: if Y[31:32-step]==0, then Y<=Y<<step and S[4-k]<=1.
    - Right: if Y[step-1:0]==0, then Y<=Y>>step and S[4-k]<=1.
    - Vacated bits are 0.
  - After stage 4 (5th RUN edge): ZERO<=(Y_final==0), BUSY<=0, DONE<=1, state->DONE.
  - DONE: DONE=1 for exactly this cycle.
    - START=1 here is accepted exactly as in IDLE (back-to-back ops), with state->RUN; DONE deasserts.
    - Otherwise state->IDLE.
- Latency: START accepted at edge n; DONE high in the cycle after edge n+5. Throughput is one op per 6 cycles.
- START while in RUN is ignored, and D/LnR changes during RUN have no effect.
- Y, S and ZERO hold their values from DONE until the next accepted START. They may change during RUN (intermediate values) and are valid only from DONE.
- Zero operand: all stages shift, giving Y=0, S=5'h1F, ZERO=1, in either direction.
- Already-normalized operand (D[31]=1 for left, D[0]=1 for right): S=0, Y=D.
- Sum rule: S is the exact count of leading zeros (left) or trailing zeros (right) for D!=0. Range is 0..31; no overflow.

Optional Feature:
- ROUNDTRIP_CHECK_EN
  - Defined: instantiate BARREL_SHIFTER32 with inputs (Y, S, ~LnR_latched) and compare its output to the captured copy of D. Adds output port CHK_ERR (1 bit, reset 0), updated on the DONE edge: 1 if the comparison fails and ZERO=0, else 0. It holds until the next DONE.
  - Undefined: no shifter instance, no D copy register, no CHK_ERR port. Remaining behaviour is identical.

Decomposition:
- Shared constants go in prj_definition.v: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10), DATA_WIDTH, SHIFT_WIDTH, and the last stage index (4).
- Sub-module norm_step: combinational; inputs word, step, dir; outputs shifted word and hit flag. It is instantiated once and indexed by the stage counter.
- BARREL_SHIFTER32 is reused unmodified under the macro.

Test Plan:
1. Reset, then START with LnR=1, D=32'h00000001 -> BUSY for 5 cycles; DONE pulse 6 cycles after accept; Y=32'h80000000, S=5'h1F, ZERO=0.
2. LnR=0, D=32'h80000000 -> Y=32'h00000001, S=5'h1F. Then LnR=1, D=32'h0000F000 -> Y=32'hF0000000, S=5'h10.
3. LnR=1, D=32'h101F568A -> Y=32'h80FAB450, S=5'h03. Then LnR=0, D=32'h198AF7B1 -> Y unchanged, S=0.
4. D=32'h00000000 (each direction) -> Y=0, S=5'h1F, ZERO=1. With ROUNDTRIP_CHECK_EN, CHK_ERR=0 on all cases above.
5. START pulsed and D changed during RUN -> result matches the first operand, and DONE pulses once. START held high in the DONE cycle -> second op accepted, DONE 6 cycles later.
6. RST low during the 3rd RUN cycle -> all outputs 0 immediately (asynchronous). After release, no DONE until a new START.
